// File: rtl/timelock_pkg.sv
// timelock_pkg: shared command codes, transfer sizes and host state encoding
// for the timelock nibble command protocol.
package timelock_pkg;

  localparam int unsigned NIBBLES = 92;
  localparam int unsigned WIDTH   = 4 * NIBBLES;
  localparam int unsigned CNT_W   = 7;

  typedef enum logic [3:0] {
    CMD_LOAD       = 4'd0,
    CMD_ACKLOAD    = 4'd1,
    CMD_COMPUTE    = 4'd2,
    CMD_ACKCOMPUTE = 4'd3
  } cmd_e;

  // One protocol byte on the serial link.
  typedef struct packed {
    logic [3:0] payload;
    cmd_e       code;
  } cmd_byte_t;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LOAD_SEND = 3'd1,
    ST_LOAD_WAIT = 3'd2,
    ST_CMP_SEND  = 3'd3,
    ST_CMP_WAIT  = 3'd4,
    ST_READ_SEND = 3'd5,
    ST_READ_WAIT = 3'd6
  } host_state_e;

  function automatic cmd_byte_t cmd_byte(input logic [3:0] payload, input cmd_e code);
    cmd_byte_t b;
    b.payload = payload;
    b.code    = code;
    return b;
  endfunction

endpackage

// File: rtl/timelock_host_if.sv
// timelock_host_if: harness start/done bus plus UART byte interfaces of the
// timelock host. slave = the host block, master = whoever drives it.
interface timelock_host_if import timelock_pkg::*; ();

  logic             start;
  logic [WIDTH-1:0] operand;
  logic             busy;
  logic             done;
  logic             error;
  logic [WIDTH-1:0] result;
  logic [7:0]       put_byte;
  logic             new_put_byte;
  logic             tx_ready;
  logic [7:0]       get_byte;
  logic             new_get_byte;

  modport slave (
    input  start, operand, tx_ready, get_byte, new_get_byte,
    output busy, done, error, result, put_byte, new_put_byte
  );

  modport master (
    output start, operand, tx_ready, get_byte, new_get_byte,
    input  busy, done, error, result, put_byte, new_put_byte
  );

endinterface

// File: rtl/timelock_host_xfer.sv
// timelock_host_xfer: send-one-byte / await-one-reply handshake for the host
// FSM. Optional reply watchdog under macro TIMELOCK_HOST_TIMEOUT_EN.
module timelock_host_xfer import timelock_pkg::*;
`ifdef TIMELOCK_HOST_TIMEOUT_EN
#(
  parameter int unsigned TIMEOUT_CYCLES = 1000000
)
`endif
(
  input  logic        clk,
  input  logic        rst,
  input  host_state_e i_state,
  input  logic [3:0]  i_nibble,
  input  logic        i_tx_ready,
  input  logic        i_new_get_byte,
  input  logic [3:0]  i_code,
  output logic [7:0]  o_put_byte,
  output logic        o_new_put_byte,
  output logic        o_sent_c,
  output logic        o_reply_ok_c,
  output logic        o_reply_bad_c,
  output logic        o_timeout_c
);

  logic      r_new_put_byte;
  logic [7:0] r_put_byte;
  logic      w_sending;
  logic      w_waiting;
  cmd_e      w_expect;
  cmd_byte_t w_byte;

  assign w_sending = (i_state == ST_LOAD_SEND) || (i_state == ST_CMP_SEND) ||
                     (i_state == ST_READ_SEND);
  assign w_waiting = (i_state == ST_LOAD_WAIT) || (i_state == ST_CMP_WAIT) ||
                     (i_state == ST_READ_WAIT);
  assign w_expect  = (i_state == ST_CMP_WAIT) ? CMD_ACKCOMPUTE : CMD_ACKLOAD;

  assign o_sent_c      = w_sending && i_tx_ready;
  assign o_reply_ok_c  = w_waiting && i_new_get_byte && (i_code == w_expect);
  assign o_reply_bad_c = w_waiting && i_new_get_byte && (i_code != w_expect);

  // Command byte for the current send state; read-back loads carry no payload.
  always_comb begin
    w_byte = cmd_byte(4'h0, CMD_LOAD);
    if (i_state == ST_LOAD_SEND) begin
      w_byte = cmd_byte(i_nibble, CMD_LOAD);
    end else if (i_state == ST_CMP_SEND) begin
      w_byte = cmd_byte(4'h0, CMD_COMPUTE);
    end
  end

  // Register the byte and a one-cycle strobe once the transmitter accepts.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_put_byte     <= 8'h00;
      r_new_put_byte <= 1'b0;
    end else begin
      r_new_put_byte <= o_sent_c;
      if (o_sent_c) begin
        r_put_byte <= w_byte;
      end
    end
  end

  assign o_put_byte     = r_put_byte;
  assign o_new_put_byte = r_new_put_byte;

`ifdef TIMELOCK_HOST_TIMEOUT_EN
  localparam int unsigned WD_W = 32;

  logic [WD_W-1:0] r_wd_cnt;
  logic            w_timed;

  // COMPUTE may legitimately take arbitrarily long, so only load replies are timed.
  assign w_timed = (i_state == ST_LOAD_WAIT) || (i_state == ST_READ_WAIT);

  // Watchdog restarts with every sent byte and counts wait cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wd_cnt <= '0;
    end else if (o_sent_c) begin
      r_wd_cnt <= '0;
    end else if (w_timed) begin
      r_wd_cnt <= r_wd_cnt + WD_W'(1);
    end
  end

  assign o_timeout_c = w_timed && (r_wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));
`else
  assign o_timeout_c = 1'b0;
`endif

endmodule

// File: rtl/timelock_host.sv
// timelock_host: streams a 368-bit operand to the timelock controller as 92
// LOADs, issues COMPUTE, then reads the result back with 92 LOADs.
// Optional reply watchdog under macro TIMELOCK_HOST_TIMEOUT_EN.
module timelock_host import timelock_pkg::*;
`ifdef TIMELOCK_HOST_TIMEOUT_EN
#(
  parameter int unsigned TIMEOUT_CYCLES = 1000000
)
`endif
(
  input  logic           clk,
  input  logic           rst,
  timelock_host_if.slave host
);

  host_state_e      r_state, w_state_nxt;
  logic [WIDTH-1:0] r_opreg, w_opreg_nxt;
  logic [WIDTH-1:0] r_result, w_result_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             r_busy, w_busy_nxt;
  logic             r_done, w_done_nxt;
  logic             r_error, w_error_nxt;
  logic             w_sent, w_reply_ok, w_reply_bad, w_timeout, w_last;

  assign w_last = (r_cnt == CNT_W'(NIBBLES - 1));

  timelock_host_xfer
`ifdef TIMELOCK_HOST_TIMEOUT_EN
    #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES))
`endif
    u_xfer (
      .clk            (clk),
      .rst            (rst),
      .i_state        (r_state),
      .i_nibble       (r_opreg[3:0]),
      .i_tx_ready     (host.tx_ready),
      .i_new_get_byte (host.new_get_byte),
      .i_code         (host.get_byte[3:0]),
      .o_put_byte     (host.put_byte),
      .o_new_put_byte (host.new_put_byte),
      .o_sent_c       (w_sent),
      .o_reply_ok_c   (w_reply_ok),
      .o_reply_bad_c  (w_reply_bad),
      .o_timeout_c    (w_timeout)
    );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and next datapath/output values.
  always_comb begin
    w_state_nxt  = r_state;
    w_opreg_nxt  = r_opreg;
    w_result_nxt = r_result;
    w_cnt_nxt    = r_cnt;
    w_busy_nxt   = r_busy;
    w_done_nxt   = 1'b0;
    w_error_nxt  = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (host.start) begin
          w_opreg_nxt = host.operand;
          w_cnt_nxt   = '0;
          w_busy_nxt  = 1'b1;
          w_state_nxt = ST_LOAD_SEND;
        end
      end
      ST_LOAD_SEND: begin
        if (w_sent) begin
          w_opreg_nxt = r_opreg >> 4;
          w_state_nxt = ST_LOAD_WAIT;
        end
      end
      ST_LOAD_WAIT: begin
        if (w_reply_ok) begin
          w_cnt_nxt   = w_last ? '0 : r_cnt + CNT_W'(1);
          w_state_nxt = w_last ? ST_CMP_SEND : ST_LOAD_SEND;
        end else if (w_reply_bad || w_timeout) begin
          w_error_nxt = 1'b1;
          w_busy_nxt  = 1'b0;
          w_state_nxt = ST_IDLE;
        end
      end
      ST_CMP_SEND: begin
        if (w_sent) begin
          w_state_nxt = ST_CMP_WAIT;
        end
      end
      ST_CMP_WAIT: begin
        if (w_reply_ok) begin
          w_state_nxt = ST_READ_SEND;
        end else if (w_reply_bad) begin
          w_error_nxt = 1'b1;
          w_busy_nxt  = 1'b0;
          w_state_nxt = ST_IDLE;
        end
      end
      ST_READ_SEND: begin
        if (w_sent) begin
          w_state_nxt = ST_READ_WAIT;
        end
      end
      ST_READ_WAIT: begin
        if (w_reply_ok) begin
          w_result_nxt = {host.get_byte[7:4], r_result[WIDTH-1:4]};
          w_cnt_nxt    = w_last ? '0 : r_cnt + CNT_W'(1);
          w_done_nxt   = w_last;
          w_busy_nxt   = !w_last;
          w_state_nxt  = w_last ? ST_IDLE : ST_READ_SEND;
        end else if (w_reply_bad || w_timeout) begin
          w_error_nxt = 1'b1;
          w_busy_nxt  = 1'b0;
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_busy_nxt  = 1'b0;
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_opreg  <= '0;
      r_result <= '0;
      r_cnt    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_error  <= 1'b0;
    end else begin
      r_opreg  <= w_opreg_nxt;
      r_result <= w_result_nxt;
      r_cnt    <= w_cnt_nxt;
      r_busy   <= w_busy_nxt;
      r_done   <= w_done_nxt;
      r_error  <= w_error_nxt;
    end
  end

  assign host.busy   = r_busy;
  assign host.done   = r_done;
  assign host.error  = r_error;
  assign host.result = r_result;

endmodule

// File: tb/tb_timelock_host.sv
// tb_timelock_host: directed bench for timelock_host with a behavioural
// timelock controller answering on the byte interface.
// Build with TIMELOCK_HOST_TIMEOUT_EN to exercise the reply watchdog.
module tb_timelock_host;
  import timelock_pkg::*;

  localparam logic [WIDTH-1:0] RES = 368'h1234_5678;
  localparam int REPLY_DLY = 2;

  logic clk = 1'b0;
  logic rst;

  timelock_host_if bus ();

`ifdef TIMELOCK_HOST_TIMEOUT_EN
  timelock_host #(.TIMEOUT_CYCLES(100)) dut (.clk(clk), .rst(rst), .host(bus));
`else
  timelock_host dut (.clk(clk), .rst(rst), .host(bus));
`endif

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Controller model state and observations.
  logic [WIDTH-1:0] m_x = '0;
  logic [WIDTH-1:0] x_at_cmp;
  logic [7:0] log_q[$];
  logic [7:0] pend_byte;
  int pend, cyc, t_send, t_err;
  int done_cnt, errp_cnt, both_cnt, busy_late, overlap, cmp_sent, load_cnt;
  int bad_at = 0;
  int silent_from = 0;
  bit ended;

  task automatic chk(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear();
    log_q.delete();
    pend = 0; done_cnt = 0; errp_cnt = 0; both_cnt = 0; busy_late = 0;
    overlap = 0; cmp_sent = 0; load_cnt = 0; t_send = -1; t_err = -1;
    x_at_cmp = 'x;
  endtask

  function automatic logic [7:0] exp_byte(input logic [WIDTH-1:0] op, input int i);
    if (i < int'(NIBBLES)) return {op[4*i +: 4], 4'h0};
    if (i == int'(NIBBLES)) return 8'h02;
    return 8'h00;
  endfunction

  function automatic int seq_bad(input logic [WIDTH-1:0] op);
    int n = 0;
    foreach (log_q[i]) if (log_q[i] !== exp_byte(op, i)) n++;
    return n;
  endfunction

  function automatic logic [7:0] log_at(input int i);
    if (i < log_q.size()) return log_q[i];
    return 8'hxx;
  endfunction

  // Controller: ack each command after REPLY_DLY cycles.
  task automatic model_rx(input logic [7:0] b);
    logic [7:0] reply;
    bit quiet = 1'b0;
    log_q.push_back(b);
    if (log_q.size() == 1) t_send = cyc;
    if (pend > 0) overlap++;
    if (b[3:0] == CMD_COMPUTE) begin
      cmp_sent++;
      x_at_cmp = m_x;
      m_x = RES;
      reply = 8'h03;
    end else begin
      load_cnt++;
      reply = {m_x[3:0], 4'h1};
      m_x = {b[7:4], m_x[WIDTH-1:4]};
      if (load_cnt == bad_at) reply = 8'h05;
      if (silent_from > 0 && load_cnt >= silent_from) quiet = 1'b1;
    end
    if (!quiet) begin
      pend = REPLY_DLY;
      pend_byte = reply;
    end
  endtask

  // One clock: sample DUT 1 ns after the edge, then drive model outputs.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    bus.new_get_byte = 1'b0;
    if (pend > 0) begin
      pend--;
      if (pend == 0) begin
        bus.get_byte = pend_byte;
        bus.new_get_byte = 1'b1;
      end
    end
    if (bus.done) done_cnt++;
    if (bus.error) begin errp_cnt++; t_err = cyc; end
    if (bus.done && bus.error) both_cnt++;
    if ((bus.done || bus.error) && bus.busy) busy_late++;
    if (bus.new_put_byte) model_rx(bus.put_byte);
  endtask

  task automatic run_to_end(input int budget);
    ended = 1'b0;
    for (int i = 0; i < budget; i++) begin
      step();
      if (done_cnt + errp_cnt > 0) begin ended = 1'b1; break; end
    end
    repeat (5) step();
  endtask

  task automatic pulse_start(input logic [WIDTH-1:0] op);
    bus.operand = op;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
  endtask

  initial begin
    cyc = 0;
    rst = 1'b1;
    bus.start = 1'b1;
    bus.operand = 368'h1;
    bus.tx_ready = 1'b1;
    bus.get_byte = 8'h00;
    bus.new_get_byte = 1'b0;
    clear();

    // Reset values, with start held high throughout reset.
    repeat (3) step();
    chk("rst_busy", WIDTH'(bus.busy), '0);
    chk("rst_done", WIDTH'(bus.done), '0);
    chk("rst_error", WIDTH'(bus.error), '0);
    chk("rst_result", bus.result, '0);
    chk("rst_put_byte", WIDTH'(bus.put_byte), '0);
    chk("rst_new_put", WIDTH'(bus.new_put_byte), '0);
    rst = 1'b0;
    bus.start = 1'b0;
    repeat (2) step();
    chk("start_in_rst", WIDTH'(bus.busy), '0);

    // Full transaction, operand = 1.
    clear();
    pulse_start(368'h1);
    chk("busy_rise", WIDTH'(bus.busy), WIDTH'(1));
    run_to_end(3000);
    chk("full_end", WIDTH'(ended), WIDTH'(1));
    chk("full_nbytes", WIDTH'(log_q.size()), WIDTH'(185));
    chk("full_first", WIDTH'(log_at(0)), WIDTH'(8'h10));
    chk("full_seq", WIDTH'(seq_bad(368'h1)), '0);
    chk("full_cmp", WIDTH'(cmp_sent), WIDTH'(1));
    chk("full_x", x_at_cmp, 368'h1);
    chk("full_done", WIDTH'(done_cnt), WIDTH'(1));
    chk("full_err", WIDTH'(errp_cnt), '0);
    chk("full_result", bus.result, RES);
    chk("full_busy_fall", WIDTH'(busy_late), '0);
    chk("full_overlap", WIDTH'(overlap), '0);
    chk("full_busy", WIDTH'(bus.busy), '0);

    // Bad ack on the 3rd LOAD.
    clear();
    bad_at = 3;
    pulse_start(368'h1);
    run_to_end(1000);
    bad_at = 0;
    chk("bad_err", WIDTH'(errp_cnt), WIDTH'(1));
    chk("bad_done", WIDTH'(done_cnt), '0);
    chk("bad_busy", WIDTH'(bus.busy), '0);
    chk("bad_busy_fall", WIDTH'(busy_late), '0);
    chk("bad_nbytes", WIDTH'(log_q.size()), WIDTH'(3));
    chk("bad_no_cmp", WIDTH'(cmp_sent), '0);
    chk("bad_result", bus.result, RES);

    // Backpressure in LOAD_SEND plus an ignored second start.
    clear();
    bus.tx_ready = 1'b0;
    pulse_start(368'h5);
    repeat (20) step();
    pulse_start(368'h7);
    repeat (29) step();
    chk("bp_stall", WIDTH'(log_q.size()), '0);
    bus.tx_ready = 1'b1;
    step();
    chk("bp_first", WIDTH'(log_q.size()), WIDTH'(1));
    step();
    chk("bp_once", WIDTH'(log_q.size()), WIDTH'(1));
    run_to_end(3000);
    chk("bp_end", WIDTH'(ended), WIDTH'(1));
    chk("bp_byte0", WIDTH'(log_at(0)), WIDTH'(8'h50));
    chk("bp_seq", WIDTH'(seq_bad(368'h5)), '0);
    chk("bp_nbytes", WIDTH'(log_q.size()), WIDTH'(185));
    chk("bp_x", x_at_cmp, 368'h5);
    chk("bp_done", WIDTH'(done_cnt), WIDTH'(1));
    chk("bp_result", bus.result, RES);

    // Silent controller after the first LOAD.
    clear();
    silent_from = 1;
    pulse_start(368'h9);
`ifdef TIMELOCK_HOST_TIMEOUT_EN
    run_to_end(500);
    chk("to_end", WIDTH'(ended), WIDTH'(1));
    chk("to_err", WIDTH'(errp_cnt), WIDTH'(1));
    chk("to_delay", WIDTH'(t_err - t_send), WIDTH'(100));
    chk("to_busy", WIDTH'(bus.busy), '0);
`else
    repeat (300) step();
    chk("noto_busy", WIDTH'(bus.busy), WIDTH'(1));
    chk("noto_err", WIDTH'(errp_cnt), '0);
`endif
    chk("silent_nbytes", WIDTH'(log_q.size()), WIDTH'(1));
    silent_from = 0;
    rst = 1'b1;
    repeat (2) step();
    rst = 1'b0;
    step();

    // Reset mid-LOAD after 40 bytes, then a clean transaction.
    clear();
    pulse_start(368'h3);
    for (int i = 0; i < 1000 && log_q.size() < 40; i++) step();
    chk("mid_40", WIDTH'(log_q.size()), WIDTH'(40));
    pend = 0;
    rst = 1'b1;
    repeat (2) step();
    chk("mid_busy", WIDTH'(bus.busy), '0);
    chk("mid_no_err", WIDTH'(errp_cnt), '0);
    chk("mid_new_put", WIDTH'(bus.new_put_byte), '0);
    rst = 1'b0;
    step();
    clear();
    pulse_start(368'hFF);
    run_to_end(3000);
    chk("re_end", WIDTH'(ended), WIDTH'(1));
    chk("re_done", WIDTH'(done_cnt), WIDTH'(1));
    chk("re_err", WIDTH'(errp_cnt), '0);
    chk("re_both", WIDTH'(both_cnt), '0);
    chk("re_nbytes", WIDTH'(log_q.size()), WIDTH'(185));
    chk("re_seq", WIDTH'(seq_bad(368'hFF)), '0);
    chk("re_x", x_at_cmp, 368'hFF);
    chk("re_result", bus.result, RES);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/timelock_host.md
# timelock_host

Host-side initiator for the timelock controller's nibble command protocol. It takes a 368-bit operand through a parallel start/done interface and streams it to the controller as 92 LOAD commands. It then issues COMPUTE, waits for ACKCOMPUTE, and reads the 368-bit result back with 92 further LOAD commands. It sits between a local test harness and a UART transmitter/receiver pair, on the side of the serial link opposite the controller.

## Interface
- `NIBBLES`, 92: nibbles per transfer.
- `WIDTH`, 368: operand/result width; must equal 4*NIBBLES.
- `TIMEOUT_CYCLES`, 1000000: reply watchdog limit; used only with the timeout feature.
- `clk` in 1: single clock for all logic, including the byte interfaces.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: begin a transaction; sampled only in IDLE.
- `operand` in WIDTH: `{xc, xs}`. Captured on accepted `start`.
- `busy` out 1: transaction in progress.
- `done` out 1: one-cycle pulse; `result` is valid from this pulse.
- `error` out 1: one-cycle pulse; the transaction was aborted.
- `result` out WIDTH: `{yc, ys}`. Held until the next accepted `start`.
- `put_byte` out 8: byte to the UART transmitter.
- `new_put_byte` out 1: one-cycle send strobe.
- `tx_ready` in 1: transmitter can accept a byte.
- `get_byte` in 8: byte from the UART receiver.
- `new_get_byte` in 1: one-cycle receive strobe.

## Operation
- Command byte format: `{payload[3:0], code[3:0]}`. Codes: LOAD=0, ACKLOAD=1, COMPUTE=2, ACKCOMPUTE=3.
- States:
  - IDLE
  - LOAD_SEND, LOAD_WAIT
  - CMP_SEND, CMP_WAIT
  - READ_SEND, READ_WAIT
- IDLE behaviour:
  - `start` captures `operand` into a shift register and clears the 7-bit nibble counter.
  - Next state is LOAD_SEND.
- Any *_SEND state: when `tx_ready` is high, drive `put_byte` and pulse `new_put_byte` for one cycle, then go to the matching *_WAIT.
- LOAD phase:
  - Each LOAD carries `opreg[3:0]`, nibble 0 first; the shift register then shifts right by 4.
  - Nibble 0 first leaves `operand[3:0]` in controller `x[3:0]` after 92 loads.
- LOAD_WAIT:
  - `new_get_byte` with `get_byte[3:0]`==ACKLOAD → reply upper nibble (stale controller contents) is discarded.
  - Then go to LOAD_SEND; after the 92nd reply, go to CMP_SEND.
- CMP phase:
  - CMP_SEND sends 8'h02.
  - CMP_WAIT waits, unbounded, for a byte with `get_byte[3:0]`==ACKCOMPUTE, then goes to READ_SEND.
- READ phase:
  - Each LOAD sends 8'h00.
  - Each ACKLOAD reply does `result <= {get_byte[7:4], result[WIDTH-1:4]}`.
  - After 92 replies, `result[3:0]` holds `ys[3:0]`.
  - The 92nd reply pulses `done`, then the block returns to IDLE.
- Wrong code in any *_WAIT: pulse `error`, return to IDLE, leave `result` unchanged.
- Bytes arriving in IDLE or *_SEND are ignored.
- `start` while `busy` is ignored.
- `done` and `error` are never asserted together.
- Reset values: all outputs 0, `result` 0, state IDLE.
- Reset mid-transaction: abort immediately with no `error` pulse. The next transaction is correct because 92 loads fully overwrite controller `x`.

## Timing
- `busy` rises the cycle after an accepted `start`.
- `busy` falls in the same cycle as the `done`/`error` pulse.
- Each command byte: `new_put_byte` is high exactly one cycle, no earlier than the cycle after `tx_ready` is seen high in a *_SEND state.
- At most one outstanding command; the next byte is never sent before the reply arrives.
- Reply to send latency: 1 cycle (WAIT→SEND transition), plus any `tx_ready` stall.
- A transaction is exactly 185 sent and 185 received bytes.
- The nibble counter wraps 91→0 on each phase change.

## Configuration
- Macro `TIMELOCK_HOST_TIMEOUT_EN`.
- Defined:
  - A 32-bit counter runs in LOAD_WAIT and READ_WAIT, cleared on entry to each.
  - Reaching `TIMEOUT_CYCLES` pulses `error` and returns to IDLE.
  - CMP_WAIT is never timed.
- Undefined: no counter; all waits are unbounded.

## Structure
- Shared package `timelock_pkg`:
  - command codes LOAD, ACKLOAD, COMPUTE, ACKCOMPUTE
  - `NIBBLES`
  - the host state encoding
- One sub-module, `timelock_host_xfer`: the send-one-byte/await-one-reply handshake, including the watchdog. It reports `reply_ok`, `reply_bad` and `timeout` to the top-level FSM.

## Test plan
- Reset: after `rst`, all outputs are 0; `start`=1 during `rst` has no effect.
- Full run against a behavioural controller model whose compute returns `{yc, ys}`=368'h1234_5678:
  - `operand`=368'h1 → first `put_byte` 8'h10, then 91×8'h00, then 8'h02, then 92×8'h00.
  - `done` pulses after reply 185; `result`=368'h1234_5678.
- Bad ack: model replies 8'h05 to the 3rd LOAD → one `error` pulse, `busy` falls, no 8'h02 is ever sent, `result` unchanged.
- Backpressure: hold `tx_ready` low for 50 cycles in LOAD_SEND → `new_put_byte` stays low, then pulses exactly once; a second `start` mid-run is ignored.
- Timeout:
  - With `TIMELOCK_HOST_TIMEOUT_EN` and `TIMEOUT_CYCLES`=100, the model is silent after the first LOAD → `error` pulses 100 cycles after the send.
  - Without the macro, `busy` stays high indefinitely.
- Reset mid-LOAD after 40 bytes, then restart with `operand`=368'hFF → correct `result` and `done` with no residue from the aborted run.
